// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer. It drives one external 4-bit ripple-carry
// slice for one nibble per cycle, least significant nibble first, and registers the carry between slices.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       sl_a,
    output logic [3:0]       sl_b,
    output logic             sl_cin,
    input  logic [3:0]       sl_s,
    input  logic             sl_cout,
    output logic [1:0]       dbg_state_o
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready. The source holds
    // its operands until in_ready. The result stays stable while out_valid && !out_ready.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        sl_a    = 4'd0;
        sl_b    = 4'd0;
        sl_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub | op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sl_a    = a_q[{idx_q, 2'b00} +: 4];
                sl_b    = b_q[{idx_q, 2'b00} +: 4];
                sl_cin  = carry_q;
                sum_d[{idx_q, 2'b00} +: 4] = sl_s;
                carry_d = sl_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // The top nibble is written on this edge, so the flags come from the slice directly.
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (sl_s[3] != a_q[MSB]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl at WIDTH=16 with an ideal 4-bit adder on the slice port.
// An arithmetic result queue plus a cycle-count timing model are compared every cycle.
module tb_rca_seq_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic             sl_cin;
  logic [3:0]       sl_s;
  logic             sl_cout;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin),
    .sl_s(sl_s), .sl_cout(sl_cout),
    .dbg_state_o(dbg_state)
  );

  // Ideal slice adder.
  assign {sl_cout, sl_s} = sl_a + sl_b + sl_cin;

  // ---------------- reference model ----------------
  // Result packed as {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic cin, input logic sub);
    logic [WIDTH:0] full;
    int sa;
    int sb;
    int sres;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      full[WIDTH] = (a >= b);
      sres = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      sres = sa + sb + int'(cin);
    end
    v = (sres > 32767) || (sres < -32768);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  logic [WIDTH+1:0] exp_q[$];
  int  m_left    = 0;
  bit  m_done    = 1'b0;
  bit  m_started = 1'b0;

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (reset) begin
      exp_q.delete();
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else if (in_valid) begin
      exp_q.push_back(model_res(op_a, op_b, op_cin, op_sub));
      m_left = NSLICE;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 32'(in_ready), 32'(!m_done && m_left == 0));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done && exp_q.size() > 0)
        chk("result", 32'({ovf, cout, sum}), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("start_wait");
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_cin = cin;
    op_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble operands once captured: the result must come from the captured copy.
    op_a = WIDTH'($urandom_range(0, 65535));
    op_b = WIDTH'($urandom_range(0, 65535));
    op_cin = 1'($urandom_range(0, 1));
    op_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timeout("done_wait");
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [WIDTH-1:0] e_sum,
                        input logic e_cout, input logic e_ovf, output int lat);
    chk({name, "_model"}, 32'(model_res(a, b, cin, sub)), 32'({e_ovf, e_cout, e_sum}));
    start_op(a, b, cin, sub);
    wait_done(lat);
    chk({name, "_sum"}, 32'(sum), 32'(e_sum));
    chk({name, "_cout"}, 32'(cout), 32'(e_cout));
    chk({name, "_ovf"}, 32'(ovf), 32'(e_ovf));
  endtask

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
  } vec_t;

  initial begin
    int lat;
    logic [WIDTH-1:0] held_sum;
    logic held_cout;
    logic held_ovf;
    vec_t extra[4];

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;
    op_sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_slice", 32'({sl_a, sl_b, sl_cin}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: plain add, latency NSLICE edges after the accept edge (NSLICE+1 cycles incl. accept)
    run_op("add1", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, lat);
    chk("add1_latency", 32'(lat), 32'(NSLICE));
    release_result();

    // 2: carry through every slice
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, lat);
    release_result();

    // 3: subtract with borrow, op_cin ignored
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, lat);
    release_result();

    // 4: signed overflow both directions
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, lat);
    release_result();
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, lat);

    // 5: sink stalls for 3 cycles
    held_sum = sum;
    held_cout = cout;
    held_ovf = ovf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'h7FFF);
      chk("hold_flags", 32'({cout, ovf}), 32'({held_cout, held_ovf}));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    release_result();
    chk("after_accept_in_ready", 32'(in_ready), 32'd1);
    chk("after_accept_out_valid", 32'(out_valid), 32'd0);
    chk("after_accept_sum", 32'(sum), 32'(held_sum));

    // 6: reset with idx=2 in RUN
    start_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_flags", 32'({cout, ovf}), 32'd0);
    run_op("post_rst", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, lat);
    release_result();

    // Extra directed vectors checked by the model only.
    extra[0] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sub: 1'b0};
    extra[1] = '{a: 16'h1234, b: 16'h1234, cin: 1'b0, sub: 1'b1};
    extra[2] = '{a: 16'hA5A5, b: 16'h5A5A, cin: 1'b1, sub: 1'b0};
    extra[3] = '{a: 16'h0000, b: 16'hFFFF, cin: 1'b0, sub: 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_op(extra[i].a, extra[i].b, extra[i].cin, extra[i].sub);
      wait_done(lat);
      release_result();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
